// File: rtl/muldiv_unit.sv
// Iterative MIPS HI/LO unit: 32-step shift-add multiply and restoring divide,
// owns the architectural HI/LO registers and requests a stall while busy.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mf_val
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] F_MFHI   = 6'h10;
  localparam logic [5:0] F_MTHI   = 6'h11;
  localparam logic [5:0] F_MFLO   = 6'h12;
  localparam logic [5:0] F_MTLO   = 6'h13;
  localparam logic [5:0] F_MULT   = 6'h18;
  localparam logic [5:0] F_MULTU  = 6'h19;
  localparam logic [5:0] F_DIV    = 6'h1A;
  localparam logic [5:0] F_DIVU   = 6'h1B;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

  state_t      state_r, state_nx_s;
  logic [4:0]  cnt_r;
  logic [63:0] acc_r;
  logic [31:0] opb_r;
  logic        is_div_r, neg_q_r, neg_r_r, busy_r, done_r;
  logic [31:0] hi_r, lo_r;

  logic        hl_funct_s, md_funct_s, mul_op_s, signed_op_s, hit_s, start_s;
  logic [31:0] mag_a_s, mag_b_s;
  logic        neg_q_s, neg_r_s;
  logic [32:0] mul_sum_s;
  logic [63:0] mul_next_s, div_next_s, prod_s;
  logic        div_ge_s;
  logic [31:0] div_diff_s, quo_s, rem_s;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    neg32 = ~v + 32'd1;
  endfunction

  // Decode of the eight HI/LO functs
  always_comb begin
    hl_funct_s = 1'b0;
    md_funct_s = 1'b0;
    case (funct)
      F_MFHI, F_MTHI, F_MFLO, F_MTLO: begin
        hl_funct_s = 1'b1;
        md_funct_s = 1'b0;
      end
      F_MULT, F_MULTU, F_DIV, F_DIVU: begin
        hl_funct_s = 1'b1;
        md_funct_s = 1'b1;
      end
      default: begin
        hl_funct_s = 1'b0;
        md_funct_s = 1'b0;
      end
    endcase
  end

  assign mul_op_s    = (funct == F_MULT) | (funct == F_MULTU);
  assign signed_op_s = (funct == F_MULT) | (funct == F_DIV);
  assign hit_s       = valid & (opcode == OP_RTYPE) & hl_funct_s;
  assign start_s     = hit_s & md_funct_s & (state_r == IDLE);

  // Operand magnitudes and result signs; a zero divisor keeps the raw
  // dividend unsigned so the restoring loop leaves it as the remainder.
  always_comb begin
    mag_a_s = rs_val;
    mag_b_s = rt_val;
    neg_q_s = 1'b0;
    neg_r_s = 1'b0;
    if (!mul_op_s && (rt_val == 32'd0)) begin
      mag_a_s = rs_val;
      mag_b_s = rt_val;
    end else if (signed_op_s) begin
      mag_a_s = rs_val[31] ? neg32(rs_val) : rs_val;
      mag_b_s = rt_val[31] ? neg32(rt_val) : rt_val;
      neg_q_s = rs_val[31] ^ rt_val[31];
      neg_r_s = rs_val[31];
    end else begin
      mag_a_s = rs_val;
      mag_b_s = rt_val;
    end
  end

  assign mul_sum_s  = {1'b0, acc_r[63:32]} + {1'b0, opb_r};
  assign mul_next_s = acc_r[0] ? {mul_sum_s, acc_r[31:1]} : {1'b0, acc_r[63:1]};
  assign div_ge_s   = acc_r[63:31] >= {1'b0, opb_r};
  assign div_diff_s = acc_r[62:31] - opb_r;
  assign div_next_s = div_ge_s ? {div_diff_s, acc_r[30:0], 1'b1} : {acc_r[62:0], 1'b0};

  assign prod_s = neg_q_r ? (~acc_r + 64'd1) : acc_r;
  assign quo_s  = neg_q_r ? neg32(acc_r[31:0])  : acc_r[31:0];
  assign rem_s  = neg_r_r ? neg32(acc_r[63:32]) : acc_r[63:32];

  // Next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE:    state_nx_s = start_s ? CALC : IDLE;
      CALC:    state_nx_s = (cnt_r == 5'd0) ? FIX : CALC;
      FIX:     state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nx_s;
  end

  // Datapath, HI/LO and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r    <= 5'd0;
      acc_r    <= 64'd0;
      opb_r    <= 32'd0;
      is_div_r <= 1'b0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      hi_r     <= 32'd0;
      lo_r     <= 32'd0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start_s) begin
            acc_r    <= {32'd0, mag_a_s};
            opb_r    <= mag_b_s;
            cnt_r    <= 5'd31;
            is_div_r <= ~mul_op_s;
            neg_q_r  <= neg_q_s;
            neg_r_r  <= neg_r_s;
            busy_r   <= 1'b1;
          end else if (hit_s && (funct == F_MTHI)) begin
            hi_r <= rs_val;
          end else if (hit_s && (funct == F_MTLO)) begin
            lo_r <= rs_val;
          end
        end
        CALC: begin
          acc_r <= is_div_r ? div_next_s : mul_next_s;
          if (cnt_r != 5'd0) cnt_r <= cnt_r - 5'd1;
        end
        FIX: begin
          if (is_div_r) begin
            hi_r <= rem_s;
            lo_r <= quo_s;
          end else begin
            hi_r <= prod_s[63:32];
            lo_r <= prod_s[31:0];
          end
          done_r <= 1'b1;
          busy_r <= 1'b0;
        end
        default: busy_r <= 1'b0;
      endcase
    end
  end

  assign stall  = hit_s & busy_r;
  assign mf_val = (funct == F_MFHI) ? hi_r : lo_r;
  assign busy   = busy_r;
  assign done   = done_r;
  assign hi     = hi_r;
  assign lo     = lo_r;

endmodule
